// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers; define UART_TX_SCHED_FIXED_PRIO_EN for fixed lowest-index priority.
// Latency: ready is combinational in IDLE, tx_update rises the cycle after the handshake and stays high for HOLD cycles.
// Backpressure: ready is zero through SEND and GAP; requesters hold valid and data until they are granted.
module uart_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int PACKAGE_SIZE   = 8,
    parameter int TRANSFER_SPEED = 4800,
    parameter int FREQUENCY      = 27_000_000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    input  logic [NUM_REQ*PACKAGE_SIZE-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [PACKAGE_SIZE+1:0]           tx_data_o,
    output logic                              tx_update_o,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id_o,
    output logic                              busy_o,
    output logic                              frame_done_o
);

    localparam int STROBE  = FREQUENCY / TRANSFER_SPEED;
    localparam int HOLD    = (PACKAGE_SIZE + 2) * STROBE + 1;
    localparam int CNT_MAX = (HOLD > GAP_CYCLES) ? HOLD : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] IDX_LAST  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [PTR_W-1:0]        ptr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [PACKAGE_SIZE+1:0] tx_data_q;
    logic                    tx_update_q;
    logic [PTR_W-1:0]        grant_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    win_vld;
    logic [PTR_W-1:0]        win_idx;
    logic [PACKAGE_SIZE-1:0] win_byte;
    logic [PTR_W-1:0]        ptr_d;
    logic                    hs;

    // Scan from the highest offset down so the offset closest to ptr is the last to claim the win.
    always_comb begin
        int sum;
        win_vld = 1'b0;
        win_idx = '0;
        sum     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(ptr_q) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            if (req_valid_i[sum]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(sum);
            end
        end
    end

    always_comb begin
        win_byte    = req_data_i[win_idx*PACKAGE_SIZE +: PACKAGE_SIZE];
        hs          = (state_q == ST_IDLE) && win_vld;
        req_ready_o = hs ? (NUM_REQ'(1) << win_idx) : '0;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        ptr_d       = '0;
`else
        ptr_d       = (win_idx == IDX_LAST) ? '0 : win_idx + PTR_W'(1);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            tx_data_q   <= '1;
            tx_update_q <= 1'b0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        tx_data_q   <= {1'b1, win_byte, 1'b0};
                        tx_update_q <= 1'b1;
                        grant_q     <= win_idx;
                        ptr_q       <= ptr_d;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (cnt_q == HOLD_LAST) begin
                        tx_data_q   <= '1;
                        tx_update_q <= 1'b0;
                        done_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    tx_data_q   <= '1;
                    tx_update_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_update_o  = tx_update_q;
    assign grant_id_o   = grant_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmitter between `NUM_REQ` byte producers. It accepts one byte at a time over per-requester valid/ready handshakes and builds the start/data/stop frame. It drives the transmitter's `data`/`data_update` inputs for exactly one frame, then enforces an idle gap before the next grant. It sits between the lab's byte sources (e.g. button/switch encoders, status reporters) and the transmitter.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `PACKAGE_SIZE`, 8: data bits per frame; must match the transmitter.
- `TRANSFER_SPEED`, 4800: baud rate; must match the transmitter.
- `FREQUENCY`, 27_000_000: clk frequency in Hz.
- `GAP_CYCLES`, 16: idle cycles with `tx_update` low between frames, minimum 1.
- Derived (localparam): `STROBE = FREQUENCY / TRANSFER_SPEED` (integer division); `HOLD = (PACKAGE_SIZE+2)*STROBE + 1`.
- `clk`, input, 1: single clock, all logic on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, NUM_REQ: requester i has a byte.
- `req_data`, input, NUM_REQ*PACKAGE_SIZE: byte of requester i in bits `[i*PACKAGE_SIZE +: PACKAGE_SIZE]`.
- `req_ready`, output, NUM_REQ: one-hot or zero; transfer occurs on the edge where `req_valid[i] & req_ready[i]`.
- `tx_data`, output, PACKAGE_SIZE+2: frame to transmitter, LSB sent first: `{1'b1, byte, 1'b0}`.
- `tx_update`, output, 1: transmitter enable, held high for one frame.
- `grant_id`, output, clog2(NUM_REQ): index of the last granted requester.
- `busy`, output, 1: high in SEND and GAP.
- `frame_done`, output, 1: one-cycle pulse when a frame's hold completes.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - `req_ready` is combinational from the registered state, pointer and `req_valid`.
  - The winner is the first valid requester searching from pointer `ptr` upward, wrapping modulo NUM_REQ.
  - `req_ready[winner]` = 1; all other ready bits are 0.
  - On the handshake edge:
    - latch `tx_data <= {1'b1, req_data[winner], 1'b0}`;
    - set `grant_id <= winner` and `ptr <= (winner+1) mod NUM_REQ`;
    - clear the counter and go to SEND.
  - With no valid requester, stay in IDLE and keep `ptr`.
- SEND:
  - `tx_update` = 1 and `tx_data` is stable.
  - The counter increments each cycle. After HOLD cycles in SEND, pulse `frame_done` and go to GAP.
  - The extra `+1` cycle lets the transmitter rewind its bit index before the enable drops.
- GAP:
  - `tx_update` = 0; `tx_data` returns to all ones.
  - After GAP_CYCLES cycles, go to IDLE.
- `req_ready` is 0 throughout SEND and GAP. Requesters hold valid and data until they see ready.
- Counter width is `$clog2(max(HOLD, GAP_CYCLES)+1)`. It saturates-free: compare with `==`, never wrap.
- Simultaneous valid from all requesters: each is served exactly once per NUM_REQ grants.
- A `req_valid` dropped while not granted is legal; that requester is simply skipped.

## Timing
- Reset values:
  - state IDLE, `ptr` 0, counter 0;
  - `tx_update` 0, `tx_data` all ones, `grant_id` 0;
  - `busy` 0, `frame_done` 0.
- Grant latency: `req_ready` in the same cycle `req_valid` rises while in IDLE (combinational). `tx_update` rises the cycle after the handshake edge.
- `tx_update` is high for exactly HOLD consecutive cycles. `frame_done` is high in the first GAP cycle.
- Minimum handshake-to-handshake spacing is `1 + HOLD + GAP_CYCLES` cycles.
- `rst` asserted mid-frame: the next edge forces the reset values, so `tx_update` falls and the frame is aborted. There is no `frame_done` pulse and `ptr` returns to 0.
- `busy` is registered and equals (state != IDLE).

## Configuration
- `UART_TX_SCHED_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. `ptr` is held at 0 and never updated; starvation of high indices is acceptable.
- Not defined: round-robin as described in Operation.

## Test plan
Bench parameters: `FREQUENCY=40`, `TRANSFER_SPEED=10`, `NUM_REQ=4`, `GAP_CYCLES=3`, so STROBE=4 and HOLD=41.
- Single request: `req_valid=4'b0100`, `req_data[2]=8'hA5` -> `req_ready=4'b0100` in the same cycle. Next cycle `tx_data=10'b1_1010_0101_0`, `tx_update` high for 41 cycles, `frame_done` once, `grant_id=2`.
- All four valid continuously -> grant order 0,1,2,3,0. Handshake spacing is 45 cycles. `tx_update` is low for exactly 3 cycles between frames.
- Valid during SEND or GAP -> `req_ready` stays 0. Grant happens in the first IDLE cycle.
- `rst` pulsed at cycle 20 of SEND -> next cycle `tx_update=0`, `tx_data=10'h3FF`, `busy=0`, no `frame_done`. A pending request is granted to index 0 first.
- With `UART_TX_SCHED_FIXED_PRIO_EN`, requesters 1 and 3 continuously valid -> requester 1 is granted every frame and 3 never.
- Serial check: the transmitter attached to `tx_data`/`tx_update` produces the line pattern 0, byte LSB-first, 1. Each bit lasts 4 cycles and the line returns high after the frame.
